mem_bridge: RTL and testbench
=============================

# mem_bridge

Memory bridge directly downstream of the multicycle MIPS core's memory port: it takes the core's single-word read/write requests (address from the I_or_D mux, mem_read, mem_write) and runs them against a slow, acknowledge-based word-addressed backing memory. It holds each transaction in a small FSM, returns read data with a one-cycle `ready` pulse, and flags misaligned or timed-out accesses. The core's controller waits in its memory state until `ready`.

## Interface
- `TMO`, default 255: watchdog limit in cycles spent waiting for `m_ack`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `addr`  in  32  byte address from the core.
- `wdata`  in  32  store data.
- `mem_read`  in  1  read request, level, held by the core until `ready`.
- `mem_write`  in  1  write request, level, held by the core until `ready`.
- `rdata`  out  32  registered read data, valid when `ready` follows a read.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky error flag, cleared only by `rst`.
- `m_addr`  out  30  word address, `addr[31:2]`.
- `m_wdata`  out  32  latched store data.
- `m_re`  out  1  backing-memory read strobe, held until ack.
- `m_we`  out  1  backing-memory write strobe, held until ack.
- `m_rdata`  in  32  backing-memory read data, valid with `m_ack`.
- `m_ack`  in  1  backing-memory completion, one cycle.

## Operation
- States: IDLE, RD, WR, RESP, plus DRAIN when write buffering is compiled in.
- IDLE: requests are sampled only here.
  - `mem_write` has priority; if both requests are high, the read is ignored.
  - On acceptance, latch `addr[31:2]` and `wdata`, then go to WR or RD.
  - Misaligned address (`addr[1:0]` != 0): no backing access, set `err`, go directly to RESP, `rdata` unchanged.
- RD: `m_re`=1. On `m_ack`, register `m_rdata` into `rdata` and go to RESP.
- WR: `m_we`=1. On `m_ack`, go to RESP.
- Watchdog:
  - Cleared on entry to RD or WR; increments each cycle spent there.
  - On reaching `TMO` without ack: set `err`, load `rdata` with 32'hFFFF_FFFF for reads, go to RESP.
- RESP: `ready`=1 for exactly one cycle, then IDLE.
  - A request still high in the following IDLE cycle is a new transaction.
- `m_ack` is ignored in IDLE and RESP.

## Timing
- Reset values: `rdata`=0, `ready`=0, `busy`=0, `err`=0, `m_re`=0, `m_we`=0, `m_addr`=0, `m_wdata`=0, state IDLE.
- All outputs are registered or decoded from state; there is no combinational path from `m_ack` to `ready`.
- Request high in IDLE at cycle N:
  - strobe asserted from N+1;
  - `m_ack` at cycle K gives `ready` at K+1;
  - minimum request-to-ready latency is 2 cycles.
- Misaligned request at N gives `ready` and `err` at N+1.
- Timeout: strobe high for exactly `TMO` cycles, then `ready` on the next cycle.
- `rst` mid-transaction: IDLE at the next edge; strobes drop; a late `m_ack` is ignored; `err` clears.

## Configuration
- `MEM_BRIDGE_WBUF_EN` defined: one-entry posted write.
  - An accepted aligned write goes IDLE to RESP (ready at N+1), then DRAIN with `m_we`=1 until `m_ack` or watchdog timeout, then IDLE.
  - `busy` stays high through DRAIN; requests arriving during DRAIN wait in IDLE sampling.
- Undefined: writes complete only after `m_ack`, as described in Operation; the DRAIN state does not exist.

## Structure
- Package `mem_bridge_pkg`: state enum, `ERR_RDATA` (32'hFFFF_FFFF), word-address width constant 30.
- One sub-module `mem_bridge_wdog`: clear/enable counter, parameter `TMO`, output `expired`.
- The FSM and datapath registers stay in `mem_bridge`.

## Test plan
- Read of addr 0x0000_0010 with `m_ack` 3 cycles after `m_re` and `m_rdata`=0x1234_5678 -> `m_addr`=0x4, `ready` 1 cycle, `rdata`=0x1234_5678, `err`=0.
- Write of 0xCAFE_0001 to 0x20 with `m_ack` on the first strobe cycle -> `m_we` 1 cycle, `m_wdata`=0xCAFE_0001, `ready` at N+2.
- Read and write high together at 0x8 -> write only: `m_re` never asserts.
- Read of 0x0000_0006 -> no strobe, `ready` and `err` at N+1; `err` stays high until `rst`.
- No `m_ack` with `TMO`=4 -> `m_re` high for 4 cycles, then `ready`, `err`=1, `rdata`=0xFFFF_FFFF.
- `rst` pulsed two cycles into RD, then a late `m_ack` -> IDLE, strobes low, `rdata`=0, no `ready`.
- With `MEM_BRIDGE_WBUF_EN`: write then read -> write `ready` at N+1; the read's `m_re` is delayed until the write's `m_ack`.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the mem_bridge memory bridge.
// The DRAIN state exists only when MEM_BRIDGE_WBUF_EN is defined.
package mem_bridge_pkg;

  localparam int          WADDR_W   = 30;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
`ifdef MEM_BRIDGE_WBUF_EN
    ST_DRAIN,
`endif
    ST_RESP
  } state_t;

endpackage

// File: rtl/mem_bridge_wdog.sv
// Watchdog for mem_bridge: counts cycles spent waiting on the backing memory
// and flags expiry on the TMO-th waiting cycle.
module mem_bridge_wdog #(
  parameter int TMO = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW    = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [CW-1:0] LIMIT = CW'(TMO - 1);

  logic [CW-1:0] cnt;

  // The count holds at LIMIT; the FSM leaves the waiting state on the same edge.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/mem_bridge.sv
// Bridge from the multicycle core's memory port to an ack-based word memory.
// Define MEM_BRIDGE_WBUF_EN to post writes through a one-entry buffer (DRAIN state).
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TMO = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               mem_read,
  input  logic               mem_write,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic               busy,
  output logic               err,
  output logic [WADDR_W-1:0] m_addr,
  output logic [31:0]        m_wdata,
  output logic               m_re,
  output logic               m_we,
  input  logic [31:0]        m_rdata,
  input  logic               m_ack
);

  state_t state;
  logic   wait_st;
  logic   wd_expired;
`ifdef MEM_BRIDGE_WBUF_EN
  logic   drain_pend;

  assign wait_st = (state == ST_RD) || (state == ST_WR) || (state == ST_DRAIN);
`else
  assign wait_st = (state == ST_RD) || (state == ST_WR);
`endif

  assign busy = (state != ST_IDLE);

  // Cleared whenever the FSM is not waiting, so every wait starts from zero.
  mem_bridge_wdog #(
    .TMO(TMO)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wait_st),
    .enable (wait_st),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_re    <= 1'b0;
      m_we    <= 1'b0;
`ifdef MEM_BRIDGE_WBUF_EN
      drain_pend <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_write || mem_read) begin
            m_addr  <= addr[31:2];
            m_wdata <= wdata;
            if (addr[1:0] != 2'b00) begin
              err   <= 1'b1;
              ready <= 1'b1;
              state <= ST_RESP;
            end else if (mem_write) begin
`ifdef MEM_BRIDGE_WBUF_EN
              ready      <= 1'b1;
              drain_pend <= 1'b1;
              state      <= ST_RESP;
`else
              m_we  <= 1'b1;
              state <= ST_WR;
`endif
            end else begin
              m_re  <= 1'b1;
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (m_ack) begin
            rdata <= m_rdata;
            m_re  <= 1'b0;
            ready <= 1'b1;
            state <= ST_RESP;
          end else if (wd_expired) begin
            rdata <= ERR_RDATA;
            err   <= 1'b1;
            m_re  <= 1'b0;
            ready <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_WR: begin
          if (m_ack || wd_expired) begin
            if (!m_ack) err <= 1'b1;
            m_we  <= 1'b0;
            ready <= 1'b1;
            state <= ST_RESP;
          end
        end
`ifdef MEM_BRIDGE_WBUF_EN
        ST_RESP: begin
          if (drain_pend) begin
            drain_pend <= 1'b0;
            m_we       <= 1'b1;
            state      <= ST_DRAIN;
          end else begin
            state <= ST_IDLE;
          end
        end
        // The core already saw ready for this write; only an error can still surface.
        ST_DRAIN: begin
          if (m_ack || wd_expired) begin
            if (!m_ack) err <= 1'b1;
            m_we  <= 1'b0;
            state <= ST_IDLE;
          end
        end
`else
        ST_RESP: begin
          state <= ST_IDLE;
        end
`endif
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: table of directed transactions plus
// hand-written reset-abort and (with MEM_BRIDGE_WBUF_EN) posted-write sequences.
module tb_mem_bridge;

  localparam int TMO = 4;
`ifdef MEM_BRIDGE_WBUF_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata, m_wdata, m_rdata;
  logic        mem_read, mem_write, ready, busy, err, m_re, m_we, m_ack;
  logic [29:0] m_addr;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    bit          do_rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          ack_d;
    int          exp_lat;
    int          exp_re;
    int          exp_we;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  mem_bridge #(
    .TMO(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .rdata    (rdata),
    .ready    (ready),
    .busy     (busy),
    .err      (err),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_re     (m_re),
    .m_we     (m_we),
    .m_rdata  (m_rdata),
    .m_ack    (m_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  function automatic vec_t mk(string name, bit do_rst, logic rd, logic wr,
                              logic [31:0] a, logic [31:0] wd, logic [31:0] mrd,
                              int ack_d, int lat, int re, int we,
                              logic [31:0] exp_rdata, logic exp_err);
    vec_t v;
    v.name = name;   v.do_rst = do_rst; v.rd = rd; v.wr = wr;
    v.addr = a;      v.wdata = wd;      v.mrdata = mrd;
    v.ack_d = ack_d; v.exp_lat = lat;   v.exp_re = re; v.exp_we = we;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one request, answers strobes with m_ack after ack_d extra cycles,
  // and runs until ready has been seen and the bridge is idle again.
  task automatic applyStimulus(input vec_t v, output int lat, output int re_c,
                               output int we_c, output int rdy_c, output bit done);
    int c = 0;
    int sc = 0;
    lat = -1; re_c = 0; we_c = 0; rdy_c = 0; done = 1'b0;
    mem_read = v.rd; mem_write = v.wr; addr = v.addr; wdata = v.wdata;
    m_ack = 1'b0; m_rdata = 32'hDEAD_BEEF;
    while (c < 60 && !done) begin
      @(posedge clk); #1;
      c++;
      m_ack = 1'b0;
      m_rdata = 32'hDEAD_BEEF;
      if (m_re || m_we) begin
        if (m_re) re_c++;
        if (m_we) we_c++;
        sc++;
        if (v.ack_d >= 0 && sc == v.ack_d + 1) begin
          m_ack = 1'b1;
          m_rdata = v.mrdata;
        end
      end
      if (ready) begin
        rdy_c++;
        if (lat < 0) lat = c;
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
      if (lat >= 0 && !busy) done = 1'b1;
    end
    m_ack = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int lat, re_c, we_c, rdy_c;
    bit done;

    vecs[0] = mk("rd_0x10",        0, 1, 0, 32'h10,  32'h0,         32'h1234_5678, 3, 5, 4, 0, 32'h1234_5678, 0);
    vecs[1] = mk("wr_0x20",        0, 0, 1, 32'h20,  32'hCAFE_0001, 32'h0,         0, (WB != 0) ? 1 : 2, 0, 1, 32'h1234_5678, 0);
    vecs[2] = mk("both_0x8",       0, 1, 1, 32'h8,   32'h5555_AAAA, 32'h9999_9999, 1, (WB != 0) ? 1 : 3, 0, 2, 32'h1234_5678, 0);
    vecs[3] = mk("rd_0x104",       0, 1, 0, 32'h104, 32'h0,         32'hA5A5_0F0F, 0, 2, 1, 0, 32'hA5A5_0F0F, 0);
    vecs[4] = mk("rd_mis_0x6",     0, 1, 0, 32'h6,   32'h0,         32'h1111_1111, 0, 1, 0, 0, 32'hA5A5_0F0F, 1);
    vecs[5] = mk("rd_0x40_sticky", 0, 1, 0, 32'h40,  32'h0,         32'h0BAD_F00D, 1, 3, 2, 0, 32'h0BAD_F00D, 1);
    vecs[6] = mk("rd_tmo_0x80",    1, 1, 0, 32'h80,  32'h0,         32'h0,        -1, 5, 4, 0, 32'hFFFF_FFFF, 1);
    vecs[7] = mk("wr_tmo_0x84",    1, 0, 1, 32'h84,  32'h0000_0001, 32'h0,        -1, (WB != 0) ? 1 : 5, 0, 4, 32'h0, 1);
    vecs[8] = mk("wr_mis_0x23",    1, 0, 1, 32'h23,  32'h0000_0002, 32'h0,         0, 1, 0, 0, 32'h0, 1);

    rst = 1'b1; addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    m_ack = 1'b0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rdata",   rdata,   32'h0);
    checkOutput("reset ready",   32'(ready), 32'h0);
    checkOutput("reset busy",    32'(busy),  32'h0);
    checkOutput("reset err",     32'(err),   32'h0);
    checkOutput("reset m_re",    32'(m_re),  32'h0);
    checkOutput("reset m_we",    32'(m_we),  32'h0);
    checkOutput("reset m_addr",  32'(m_addr), 32'h0);
    checkOutput("reset m_wdata", m_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_rst) doReset();
      applyStimulus(vecs[i], lat, re_c, we_c, rdy_c, done);
      checkOutput($sformatf("%s bound", vecs[i].name),   32'(done),  32'h1);
      checkOutput($sformatf("%s latency", vecs[i].name), 32'(lat),   32'(vecs[i].exp_lat));
      checkOutput($sformatf("%s re_cycles", vecs[i].name), 32'(re_c), 32'(vecs[i].exp_re));
      checkOutput($sformatf("%s we_cycles", vecs[i].name), 32'(we_c), 32'(vecs[i].exp_we));
      checkOutput($sformatf("%s ready_pulses", vecs[i].name), 32'(rdy_c), 32'h1);
      checkOutput($sformatf("%s rdata", vecs[i].name),   rdata,      vecs[i].exp_rdata);
      checkOutput($sformatf("%s err", vecs[i].name),     32'(err),   32'(vecs[i].exp_err));
      if (vecs[i].exp_re + vecs[i].exp_we > 0)
        checkOutput($sformatf("%s m_addr", vecs[i].name), 32'(m_addr), {2'b00, vecs[i].addr[31:2]});
      if (vecs[i].wr && vecs[i].exp_we > 0)
        checkOutput($sformatf("%s m_wdata", vecs[i].name), m_wdata, vecs[i].wdata);
    end

`ifdef MEM_BRIDGE_WBUF_EN
    begin
      int ack_c = -1;
      int re_first = -1;
      int wc = 0;
      bit fin = 1'b0;
      doReset();
      mem_write = 1'b1; addr = 32'h30; wdata = 32'h600D_F00D;
      @(posedge clk); #1;
      checkOutput("wbuf write ready at N+1", 32'(ready), 32'h1);
      mem_write = 1'b0; mem_read = 1'b1; addr = 32'h34;
      for (int c = 2; c < 40 && !fin; c++) begin
        @(posedge clk); #1;
        m_ack = 1'b0;
        if (m_we) begin
          wc++;
          if (wc == 2) begin m_ack = 1'b1; ack_c = c; end
        end
        if (m_re && re_first < 0) begin
          re_first = c; m_ack = 1'b1; m_rdata = 32'h1357_2468;
        end
        if (ready && re_first >= 0) begin fin = 1'b1; mem_read = 1'b0; end
      end
      m_ack = 1'b0;
      mem_read = 1'b0;
      @(posedge clk); #1;
      checkOutput("wbuf sequence bound", 32'(fin), 32'h1);
      checkOutput("wbuf drain m_wdata", m_wdata, 32'h600D_F00D);
      checkOutput("wbuf read strobe after drain ack", 32'(re_first), 32'(ack_c + 2));
      checkOutput("wbuf read rdata", rdata, 32'h1357_2468);
      checkOutput("wbuf err", 32'(err), 32'h0);
    end
`endif

    // Abort a read with rst two cycles into RD, then present a late ack.
    mem_read = 1'b1; addr = 32'h10;
    @(posedge clk); #1;
    checkOutput("abort m_re N+1", 32'(m_re), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; m_ack = 1'b1; m_rdata = 32'h7777_7777;
    checkOutput("abort m_re",  32'(m_re),  32'h0);
    checkOutput("abort busy",  32'(busy),  32'h0);
    checkOutput("abort err",   32'(err),   32'h0);
    checkOutput("abort rdata", rdata,      32'h0);
    checkOutput("abort ready", 32'(ready), 32'h0);
    @(posedge clk); #1;
    m_ack = 1'b0;
    checkOutput("late ack ready", 32'(ready), 32'h0);
    checkOutput("late ack busy",  32'(busy),  32'h0);
    checkOutput("late ack rdata", rdata,      32'h0);
    checkOutput("late ack m_re",  32'(m_re),  32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
